// File: rtl/jacobi_credit_fifo_pkg.sv
// Shared constants and lane type for the Jacobi result buffers.
// Imported by the credit FIFO, its interface and its storage.
package jacobi_credit_fifo_pkg;

  localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
  localparam int JACOBI_FIFO_DEPTH        = 16;
  localparam int JACOBI_ROT_LANES         = 2;

  typedef logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] jacobi_word_t;

  function automatic int jacobi_cnt_width(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/jacobi_credit_fifo_if.sv
// Handshake bundle between a non-stallable pipeline, the credit FIFO and its consumer.
// The master side drives the pipeline and consumer signals; the slave side is the FIFO.
interface jacobi_credit_fifo_if
  import jacobi_credit_fifo_pkg::*;
#(
  parameter int LANES = JACOBI_ROT_LANES,
  parameter int WIDTH = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int DEPTH = JACOBI_FIFO_DEPTH,
  parameter int CNT_W = jacobi_cnt_width(DEPTH)
);

  logic                   issue_i;
  logic                   credit_avail_o;
  logic [LANES*WIDTH-1:0] in_dat_i;
  logic                   in_vld_i;
  logic [LANES*WIDTH-1:0] out_dat_o;
  logic                   out_vld_o;
  logic                   out_rdy_i;
  logic                   flush_i;
  logic [CNT_W-1:0]       count_o;
  logic [CNT_W-1:0]       credits_o;
  logic                   overflow_o;
  logic                   protocol_err_o;

  modport master (
    output issue_i, in_dat_i, in_vld_i, out_rdy_i, flush_i,
    input  credit_avail_o, out_dat_o, out_vld_o, count_o, credits_o,
           overflow_o, protocol_err_o
  );

  modport slave (
    input  issue_i, in_dat_i, in_vld_i, out_rdy_i, flush_i,
    output credit_avail_o, out_dat_o, out_vld_o, count_o, credits_o,
           overflow_o, protocol_err_o
  );

endinterface

// File: rtl/jacobi_fifo_mem.sv
// Flop-array storage with one synchronous write port and one asynchronous read port.
// Cleared on reset so the head word reads as zero before the first write.
module jacobi_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jacobi_credit_fifo.sv
// Multi-lane result buffer with credit-based admission for non-stallable pipelines.
// A slot is reserved at issue time, so a correctly driven pipeline can never overflow it.
module jacobi_credit_fifo
  import jacobi_credit_fifo_pkg::*;
#(
  parameter int LANES = JACOBI_ROT_LANES,
  parameter int WIDTH = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int DEPTH = JACOBI_FIFO_DEPTH,
  parameter int CNT_W = jacobi_cnt_width(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  jacobi_credit_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = LANES * WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] count, inflight, credits;
  logic [CNT_W-1:0] count_nxt, inflight_nxt, credits_nxt;
  logic             overflow, protocol_err, overflow_nxt, protocol_err_nxt;
  logic             issue_ok, pop, push, ret, we;
  logic [DW-1:0]    rd_data;

  always_comb begin
    issue_ok         = bus.issue_i & (credits != '0);
    pop              = (count != '0) & bus.out_rdy_i;
    push             = bus.in_vld_i & ((count != DEPTH_C) | pop);
    ret              = bus.in_vld_i & (inflight != '0);
    we               = 1'b0;
    rd_ptr_nxt       = rd_ptr;
    wr_ptr_nxt       = wr_ptr;
    count_nxt        = count;
    overflow_nxt     = overflow;
    inflight_nxt     = inflight + CNT_W'(issue_ok) - CNT_W'(ret);
    credits_nxt      = credits - CNT_W'(issue_ok);
    protocol_err_nxt = protocol_err
                     | (bus.issue_i & (credits == '0))
                     | (bus.in_vld_i & (inflight == '0));
    // Flush returns stored entries' credits but keeps in-flight reservations.
    if (bus.flush_i) begin
      rd_ptr_nxt  = '0;
      wr_ptr_nxt  = '0;
      count_nxt   = '0;
      credits_nxt = credits_nxt + count;
    end else begin
      we           = push;
      wr_ptr_nxt   = push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr_nxt   = pop  ? rd_ptr + AW'(1) : rd_ptr;
      count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
      credits_nxt  = credits_nxt + CNT_W'(pop);
      overflow_nxt = overflow | (bus.in_vld_i & ~push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= '0;
      credits      <= DEPTH_C;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr_nxt;
      wr_ptr       <= wr_ptr_nxt;
      count        <= count_nxt;
      inflight     <= inflight_nxt;
      credits      <= credits_nxt;
      overflow     <= overflow_nxt;
      protocol_err <= protocol_err_nxt;
    end
  end

  // The slot accounting only balances while upstream has obeyed the credit protocol.
  always_ff @(posedge clk) begin
    if (!rst && !overflow && !protocol_err)
      assert (32'(count) + 32'(inflight) + 32'(credits) == DEPTH);
  end

  jacobi_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (bus.in_dat_i),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign bus.out_dat_o      = rd_data;
  assign bus.out_vld_o      = count != '0;
  assign bus.credit_avail_o = credits != '0;
  assign bus.count_o        = count;
  assign bus.credits_o      = credits;
  assign bus.overflow_o     = overflow;
  assign bus.protocol_err_o = protocol_err;

endmodule

// File: tb/tb_jacobi_credit_fifo.sv
// Directed bench for jacobi_credit_fifo: a queue-based reference model checked every
// cycle, plus hand-computed expectations for credit, latency, full, flush and reset cases.
module tb_jacobi_credit_fifo;
  import jacobi_credit_fifo_pkg::*;

  localparam int LANES = 2;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int DW    = LANES * WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jacobi_credit_fifo_if #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  jacobi_credit_fifo #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mq[$];
  int m_inflight = 0;
  int m_credits  = DEPTH;
  bit m_ovf = 0;
  bit m_perr = 0;
  bit model_ready = 0;

  function automatic logic [DW-1:0] pack(logic [15:0] n);
    return {n + 16'h0100, n};
  endfunction

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour: slots live in a queue, credits are plain integers.
  task automatic model_step();
    bit ok, ret, popped;
    if (rst) begin
      mq.delete();
      m_inflight  = 0;
      m_credits   = DEPTH;
      m_ovf       = 0;
      m_perr      = 0;
      model_ready = 1;
    end else begin
      ok  = bus.issue_i && m_credits > 0;
      ret = bus.in_vld_i && m_inflight > 0;
      if (bus.issue_i && !ok) m_perr = 1;
      if (bus.in_vld_i && m_inflight == 0) m_perr = 1;
      if (bus.flush_i) begin
        m_credits += mq.size();
        mq.delete();
      end else begin
        popped = mq.size() > 0 && bus.out_rdy_i;
        if (popped) begin
          void'(mq.pop_front());
          m_credits++;
        end
        if (bus.in_vld_i) begin
          if (mq.size() < DEPTH) mq.push_back(bus.in_dat_i);
          else m_ovf = 1;
        end
      end
      m_credits  -= int'(ok);
      m_inflight += int'(ok) - int'(ret);
    end
  endtask

  task automatic apply_stimulus(bit r, bit iss, bit vld, logic [DW-1:0] d, bit rdy, bit fl);
    rst           = r;
    bus.issue_i   = iss;
    bus.in_vld_i  = vld;
    bus.in_dat_i  = d;
    bus.out_rdy_i = rdy;
    bus.flush_i   = fl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, '0, rdy, 0);
  endtask

  task automatic do_reset();
    apply_stimulus(1, 0, 0, '0, 0, 0);
  endtask

  // Every cycle after the first reset, all outputs must agree with the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ready) begin
        check_output("cyc_count",   32'(bus.count_o),        32'(mq.size()));
        check_output("cyc_credits", 32'(bus.credits_o),      32'(m_credits));
        check_output("cyc_avail",   32'(bus.credit_avail_o), 32'(m_credits != 0));
        check_output("cyc_vld",     32'(bus.out_vld_o),      32'(mq.size() != 0));
        check_output("cyc_ovf",     32'(bus.overflow_o),     32'(m_ovf));
        check_output("cyc_perr",    32'(bus.protocol_err_o), 32'(m_perr));
        if (mq.size() != 0) check_output("cyc_dat", bus.out_dat_o, mq[0]);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.issue_i   = 1'b0;
    bus.in_vld_i  = 1'b0;
    bus.in_dat_i  = '0;
    bus.out_rdy_i = 1'b0;
    bus.flush_i   = 1'b0;
    do_reset();
    do_reset();

    check_output("rst_count",   32'(bus.count_o),        32'd0);
    check_output("rst_credits", 32'(bus.credits_o),      32'd16);
    check_output("rst_avail",   32'(bus.credit_avail_o), 32'd1);
    check_output("rst_vld",     32'(bus.out_vld_o),      32'd0);
    check_output("rst_dat",     bus.out_dat_o,           32'd0);
    check_output("rst_flags",   32'({bus.overflow_o, bus.protocol_err_o}), 32'd0);

    for (int i = 0; i < 16; i++) apply_stimulus(0, 1, 0, '0, 0, 0);
    check_output("exh_credits", 32'(bus.credits_o),      32'd0);
    check_output("exh_avail",   32'(bus.credit_avail_o), 32'd0);
    check_output("exh_perr0",   32'(bus.protocol_err_o), 32'd0);
    apply_stimulus(0, 1, 0, '0, 0, 0);
    check_output("exh_perr1",   32'(bus.protocol_err_o), 32'd1);
    check_output("exh_credit0", 32'(bus.credits_o),      32'd0);

    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, '0, 0, 0);
    check_output("lat_credits", 32'(bus.credits_o), 32'd13);
    check_output("lat_vld0",    32'(bus.out_vld_o), 32'd0);
    apply_stimulus(0, 0, 1, pack(16'hA), 1, 0);
    check_output("lat_vld1",    32'(bus.out_vld_o), 32'd1);
    check_output("lat_datA",    bus.out_dat_o,      32'h010A_000A);
    apply_stimulus(0, 0, 1, pack(16'hB), 1, 0);
    check_output("lat_datB",    bus.out_dat_o,      32'h010B_000B);
    check_output("lat_cred14",  32'(bus.credits_o), 32'd14);
    apply_stimulus(0, 0, 1, pack(16'hC), 1, 0);
    check_output("lat_datC",    bus.out_dat_o,      32'h010C_000C);
    idle(1, 1);
    check_output("lat_count0",  32'(bus.count_o),   32'd0);
    check_output("lat_cred16",  32'(bus.credits_o), 32'd16);

    do_reset();
    for (int i = 0; i < 16; i++) apply_stimulus(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 1, pack(16'(i)), 0, 0);
    check_output("full_count",  32'(bus.count_o),   32'd16);
    check_output("full_head",   bus.out_dat_o,      32'h0100_0000);
    apply_stimulus(0, 0, 1, pack(16'h40), 1, 0);
    check_output("pp_count",    32'(bus.count_o),    32'd16);
    check_output("pp_ovf",      32'(bus.overflow_o), 32'd0);
    check_output("pp_head",     bus.out_dat_o,       32'h0101_0001);

    apply_stimulus(0, 0, 1, pack(16'h50), 0, 0);
    check_output("ovf_flag",    32'(bus.overflow_o), 32'd1);
    check_output("ovf_count",   32'(bus.count_o),    32'd16);
    check_output("ovf_head",    bus.out_dat_o,       32'h0101_0001);
    for (int i = 0; i < 16; i++) begin
      check_output("drain_order", bus.out_dat_o, (i < 15) ? pack(16'(i + 1)) : pack(16'h40));
      idle(1, 1);
    end
    check_output("drain_empty", 32'(bus.out_vld_o), 32'd0);

    do_reset();
    for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, pack(16'(16'h60 + i)), 0, 0);
    check_output("fl_pre_cnt",  32'(bus.count_o),   32'd5);
    check_output("fl_pre_cred", 32'(bus.credits_o), 32'd8);
    apply_stimulus(0, 0, 0, '0, 1, 1);
    check_output("fl_count",    32'(bus.count_o),   32'd0);
    check_output("fl_credits",  32'(bus.credits_o), 32'd13);
    for (int i = 5; i < 8; i++) apply_stimulus(0, 0, 1, pack(16'(16'h60 + i)), 0, 0);
    check_output("fl_post_cnt", 32'(bus.count_o),        32'd3);
    check_output("fl_post_err", 32'(bus.protocol_err_o), 32'd0);
    check_output("fl_post_dat", bus.out_dat_o,           32'h0165_0065);

    do_reset();
    apply_stimulus(0, 0, 1, pack(16'h70), 0, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 1, pack(16'(16'h71 + i)), 0, 0);
    check_output("mid_count",   32'(bus.count_o),        32'd7);
    check_output("mid_perr",    32'(bus.protocol_err_o), 32'd1);
    apply_stimulus(1, 1, 1, pack(16'h99), 1, 0);
    check_output("mr_count",    32'(bus.count_o),        32'd0);
    check_output("mr_credits",  32'(bus.credits_o),      32'd16);
    check_output("mr_vld",      32'(bus.out_vld_o),      32'd0);
    check_output("mr_flags",    32'({bus.overflow_o, bus.protocol_err_o}), 32'd0);

    idle(2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
